// File: rtl/dds_ftw_writer.sv
// Serial FTW writer for AD9958/AD9959: streams CSR-select + CFTW0 writes for each
// selected channel inside one chip-select frame, then strobes IO_UPDATE once.
module dds_ftw_writer #(
    parameter int CHANNELS   = 2,
    parameter int CLK_DIV    = 2,
    parameter int UPD_CYCLES = 4
) (
    input  logic                   Sync_clk,
    input  logic                   resetq,
    input  logic [32*CHANNELS-1:0] ftw,
    input  logic [CHANNELS-1:0]    chan_mask,
    input  logic                   valid,
    output logic                   ready,
    output logic                   done,
    output logic                   dds_csb,
    output logic                   dds_sclk,
    output logic                   dds_sdio,
    output logic                   dds_io_update
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int UPD_W = (UPD_CYCLES > 1) ? $clog2(UPD_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, UPDATE} state_t;

    state_t                  state_reg, state_next;
    logic [32*CHANNELS-1:0]  ftw_reg, ftw_next;
    logic [CHANNELS-1:0]     rem_reg, rem_next;
    logic [CH_W-1:0]         cur_reg, cur_next;
    logic [5:0]              pos_reg, pos_next;
    logic [7:0]              bit_cnt_reg, bit_cnt_next;
    logic [7:0]              last_bit_reg, last_bit_next;
    logic [DIV_W-1:0]        div_reg, div_next;
    logic [UPD_W-1:0]        upd_reg, upd_next;
    logic                    ready_reg, ready_next;
    logic                    done_reg, done_next;
    logic                    csb_reg, csb_next;
    logic                    sclk_reg, sclk_next;
    logic                    sdio_reg, sdio_next;
    logic                    io_reg, io_next;
    logic [CH_W-1:0]         sel_ch;
    logic [55:0]             word;

    function automatic logic [CH_W-1:0] lowest_set(input logic [CHANNELS-1:0] m);
        lowest_set = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (m[i]) lowest_set = CH_W'(i);
    endfunction

    function automatic logic [7:0] count_set(input logic [CHANNELS-1:0] m);
        count_set = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (m[i]) count_set = count_set + 8'd1;
    endfunction

    // Per-channel 56-bit sequence: CSR write selecting this channel, then CFTW0 write.
    function automatic logic [55:0] chan_word(input logic [CH_W-1:0] ch,
                                              input logic [32*CHANNELS-1:0] f);
        chan_word = {8'h00, 8'h10 << ch, 8'h04, f[32*ch +: 32]};
    endfunction

    always_comb begin
        state_next    = state_reg;
        ftw_next      = ftw_reg;
        rem_next      = rem_reg;
        cur_next      = cur_reg;
        pos_next      = pos_reg;
        bit_cnt_next  = bit_cnt_reg;
        last_bit_next = last_bit_reg;
        div_next      = div_reg;
        upd_next      = upd_reg;
        ready_next    = ready_reg;
        done_next     = 1'b0;
        csb_next      = csb_reg;
        sclk_next     = sclk_reg;
        sdio_next     = sdio_reg;
        io_next       = io_reg;
        sel_ch        = lowest_set(rem_reg);
        word          = chan_word(cur_reg, ftw_reg);

        case (state_reg)
            IDLE: begin
                if (valid) begin
                    if (chan_mask == '0) begin
                        done_next = 1'b1;
                    end else begin
                        sel_ch        = lowest_set(chan_mask);
                        word          = chan_word(sel_ch, ftw);
                        ftw_next      = ftw;
                        cur_next      = sel_ch;
                        rem_next      = chan_mask & ~(CHANNELS'(1) << sel_ch);
                        pos_next      = '0;
                        bit_cnt_next  = '0;
                        last_bit_next = 8'd56 * count_set(chan_mask) - 8'd1;
                        div_next      = '0;
                        ready_next    = 1'b0;
                        csb_next      = 1'b0;
                        sclk_next     = 1'b0;
                        sdio_next     = word[55];
                        state_next    = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (div_reg == DIV_LAST) begin
                    div_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                    end else if (bit_cnt_reg == last_bit_reg) begin
                        csb_next   = 1'b1;
                        sclk_next  = 1'b0;
                        sdio_next  = 1'b0;
                        state_next = HOLD;
                    end else begin
                        // Bit boundary: SCLK falls and the next bit goes out together.
                        bit_cnt_next = bit_cnt_reg + 8'd1;
                        sclk_next    = 1'b0;
                        if (pos_reg == 6'd55) begin
                            word      = chan_word(sel_ch, ftw_reg);
                            cur_next  = sel_ch;
                            rem_next  = rem_reg & ~(CHANNELS'(1) << sel_ch);
                            pos_next  = '0;
                            sdio_next = word[55];
                        end else begin
                            pos_next  = pos_reg + 6'd1;
                            sdio_next = word[6'd54 - pos_reg];
                        end
                    end
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end
            HOLD: begin
                io_next    = 1'b1;
                upd_next   = '0;
                state_next = UPDATE;
            end
            UPDATE: begin
                if (upd_reg == UPD_LAST) begin
                    io_next    = 1'b0;
                    ready_next = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    upd_next = upd_reg + UPD_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Sync_clk or negedge resetq) begin
        if (!resetq) begin
            state_reg    <= IDLE;
            ftw_reg      <= '0;
            rem_reg      <= '0;
            cur_reg      <= '0;
            pos_reg      <= '0;
            bit_cnt_reg  <= '0;
            last_bit_reg <= '0;
            div_reg      <= '0;
            upd_reg      <= '0;
            ready_reg    <= 1'b1;
            done_reg     <= 1'b0;
            csb_reg      <= 1'b1;
            sclk_reg     <= 1'b0;
            sdio_reg     <= 1'b0;
            io_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ftw_reg      <= ftw_next;
            rem_reg      <= rem_next;
            cur_reg      <= cur_next;
            pos_reg      <= pos_next;
            bit_cnt_reg  <= bit_cnt_next;
            last_bit_reg <= last_bit_next;
            div_reg      <= div_next;
            upd_reg      <= upd_next;
            ready_reg    <= ready_next;
            done_reg     <= done_next;
            csb_reg      <= csb_next;
            sclk_reg     <= sclk_next;
            sdio_reg     <= sdio_next;
            io_reg       <= io_next;
        end
    end

    assign ready         = ready_reg;
    assign done          = done_reg;
    assign dds_csb       = csb_reg;
    assign dds_sclk      = sclk_reg;
    assign dds_sdio      = sdio_reg;
    assign dds_io_update = io_reg;
endmodule

// File: tb/tb_dds_ftw_writer.sv
// Bench for dds_ftw_writer: a cycle-level pin model plus a serial receiver, checked
// every cycle for a 2-channel (D=2,U=4) and a 4-channel (D=1,U=1) instance.
module tb_dds_ftw_writer;
    localparam int F_RDY = 5, F_DONE = 4, F_CSB = 3, F_SCLK = 2, F_SDIO = 1, F_IO = 0;
    localparam int DV0 = 2, UV0 = 4, DV1 = 1, UV1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][127:0] ftw_in;
    logic [1:0][3:0]   mask_in;
    logic [1:0]        valid_in;
    logic [1:0]        rstn;
    wire  [1:0]        rdy, dn, cs, sc, sd, iu;

    dds_ftw_writer #(.CHANNELS(2), .CLK_DIV(DV0), .UPD_CYCLES(UV0)) dut0 (
        .Sync_clk(clk), .resetq(rstn[0]), .ftw(ftw_in[0][63:0]), .chan_mask(mask_in[0][1:0]),
        .valid(valid_in[0]), .ready(rdy[0]), .done(dn[0]), .dds_csb(cs[0]),
        .dds_sclk(sc[0]), .dds_sdio(sd[0]), .dds_io_update(iu[0]));

    dds_ftw_writer #(.CHANNELS(4), .CLK_DIV(DV1), .UPD_CYCLES(UV1)) dut1 (
        .Sync_clk(clk), .resetq(rstn[1]), .ftw(ftw_in[1]), .chan_mask(mask_in[1]),
        .valid(valid_in[1]), .ready(rdy[1]), .done(dn[1]), .dds_csb(cs[1]),
        .dds_sclk(sc[1]), .dds_sdio(sd[1]), .dds_io_update(iu[1]));

    typedef struct {int at; int d; int kind; int idx; logic [7:0] val; string name;} exp_t;
    exp_t eq[$];

    int n_chk = 0, n_fail = 0, ecnt = 0;
    logic         active[2];
    int           te[2], nb[2], ltot[2];
    logic [223:0] bits[2];
    logic [7:0]   rx_b[2][32];
    logic [7:0]   rx_sh[2];
    int           rx_n[2], rx_bc[2], io_cnt[2];
    logic         pcs[2], psc[2], piu[2];

    function automatic int popc(input logic [3:0] m);
        popc = 0;
        for (int i = 0; i < 4; i++) if (m[i]) popc++;
    endfunction

    // Expected serial stream: for each selected channel, ascending, 7 bytes MSB first.
    function automatic logic [223:0] build_bits(input logic [3:0] m, input logic [127:0] f);
        logic [7:0] by[7];
        int k;
        build_bits = '0;
        k = 0;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                by[0] = 8'h00;
                by[1] = 8'h10 << ch;
                by[2] = 8'h04;
                for (int b = 0; b < 4; b++) by[3+b] = f[32*ch + 24 - 8*b +: 8];
                for (int b = 0; b < 7; b++)
                    for (int i = 7; i >= 0; i--) begin
                        build_bits[k] = by[b][i];
                        k++;
                    end
            end
        end
    endfunction

    // Pins in cycle T+j of a transaction: {ready, done, csb, sclk, sdio, io_update}.
    function automatic logic [5:0] expect_out(input logic act, input int j, input int nbits,
                                              input int dd, input int uu, input logic [223:0] bv);
        int fr;
        fr = 2 * nbits * dd;
        if (!act || j < 1 || j > ((nbits == 0) ? 1 : fr + 2 + uu)) return 6'b101000;
        if (nbits == 0) return 6'b111000;
        if (j <= fr) return {3'b000, ((j - 1) % (2 * dd)) >= dd, bv[(j - 1) / (2 * dd)], 1'b0};
        if (j == fr + 1) return 6'b001000;
        if (j <= fr + 1 + uu) return 6'b001001;
        return 6'b111000;
    endfunction

    // Model: accepts whenever valid is seen and the previous transaction has run out.
    initial begin
        for (int d = 0; d < 2; d++) begin
            active[d] = 1'b0; te[d] = 0; nb[d] = 0; ltot[d] = 1; bits[d] = '0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rstn[d]) begin
                    active[d] = 1'b0;
                end else if (valid_in[d] && (!active[d] || ecnt >= te[d] + ltot[d])) begin
                    active[d] = 1'b1;
                    te[d]     = ecnt;
                    nb[d]     = 56 * popc(mask_in[d]);
                    bits[d]   = build_bits(mask_in[d], ftw_in[d]);
                    ltot[d]   = (nb[d] == 0) ? 1 : 2 * nb[d] * ((d == 0) ? DV0 : DV1) + 2 + ((d == 0) ? UV0 : UV1);
                end
            end
            ecnt = ecnt + 1;
        end
    end

    initial begin
        logic [5:0] act, ex;
        logic [7:0] got;
        for (int d = 0; d < 2; d++) begin
            rx_n[d] = 0; rx_bc[d] = 0; rx_sh[d] = '0; io_cnt[d] = 0;
            pcs[d] = 1'b1; psc[d] = 1'b0; piu[d] = 1'b0;
            for (int i = 0; i < 32; i++) rx_b[d][i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                act = {rdy[d], dn[d], cs[d], sc[d], sd[d], iu[d]};
                ex  = expect_out(active[d] && rstn[d], ecnt - te[d], nb[d],
                                 (d == 0) ? DV0 : DV1, (d == 0) ? UV0 : UV1, bits[d]);
                n_chk++;
                if (act !== ex) begin
                    n_fail++;
                    $display("FAIL model dut%0d cycle T+%0d: got %b required %b (rdy,done,csb,sclk,sdio,upd)",
                             d, ecnt - te[d], act, ex);
                end
                if (pcs[d] && !cs[d]) begin rx_n[d] = 0; rx_bc[d] = 0; end
                if (!cs[d] && sc[d] && !psc[d]) begin
                    rx_sh[d] = {rx_sh[d][6:0], sd[d]};
                    rx_bc[d]++;
                    if (rx_bc[d] == 8) begin
                        if (rx_n[d] < 32) rx_b[d][rx_n[d]] = rx_sh[d];
                        rx_n[d]++;
                        rx_bc[d] = 0;
                    end
                end
                if (iu[d] && !piu[d]) io_cnt[d]++;
                pcs[d] = cs[d]; psc[d] = sc[d]; piu[d] = iu[d];
            end
            for (int i = eq.size() - 1; i >= 0; i--) begin
                if (eq[i].at == ecnt) begin
                    case (eq[i].kind)
                        0:       got = {7'b0, act_bit(eq[i].d, eq[i].idx)};
                        1:       got = rx_b[eq[i].d][eq[i].idx];
                        2:       got = 8'(rx_n[eq[i].d]);
                        default: got = 8'(io_cnt[eq[i].d]);
                    endcase
                    n_chk++;
                    if (got !== eq[i].val) begin
                        n_fail++;
                        $display("FAIL %s: got %0h required %0h", eq[i].name, got, eq[i].val);
                    end
                    eq.delete(i);
                end
            end
        end
    end

    function automatic logic act_bit(input int d, input int f);
        logic [5:0] v;
        v = {rdy[d], dn[d], cs[d], sc[d], sd[d], iu[d]};
        return v[f];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (ecnt < n) step();
    endtask

    task automatic go(input int d, input logic [3:0] m, input logic [127:0] f, output int t);
        ftw_in[d] = f; mask_in[d] = m; valid_in[d] = 1'b1;
        t = ecnt;
        step();
        valid_in[d] = 1'b0;
    endtask

    task automatic pin(input int at, input int d, input int f, input logic v, input string nm);
        eq.push_back('{at, d, 0, f, {7'b0, v}, nm});
    endtask

    task automatic bytes_at(input int at, input int d, input int n, input logic [111:0] v, input string nm);
        for (int i = 0; i < n; i++)
            eq.push_back('{at, d, 1, i, v[8*(n-1-i) +: 8], $sformatf("%s byte%0d", nm, i)});
        eq.push_back('{at, d, 2, 0, 8'(n), {nm, " byte count"}});
    endtask

    task automatic io_at(input int at, input int d, input int n, input string nm);
        eq.push_back('{at, d, 3, 0, 8'(n), nm});
    endtask

    initial begin
        int t, t2;
        ftw_in = '0; mask_in = '0; valid_in = '0; rstn = '0;
        repeat (3) step();
        rstn = 2'b11;
        step();
        pin(ecnt, 0, F_RDY, 1, "rst dut0 ready");  pin(ecnt, 0, F_DONE, 0, "rst dut0 done");
        pin(ecnt, 0, F_CSB, 1, "rst dut0 csb");    pin(ecnt, 0, F_SCLK, 0, "rst dut0 sclk");
        pin(ecnt, 0, F_IO, 0, "rst dut0 upd");     pin(ecnt, 1, F_RDY, 1, "rst dut1 ready");
        pin(ecnt, 1, F_CSB, 1, "rst dut1 csb");
        step();

        // One channel, D=2, U=4.
        go(0, 4'b0001, {96'h0, 32'h12345678}, t);
        pin(t+1, 0, F_CSB, 0, "t1 csb low start");  pin(t+224, 0, F_CSB, 0, "t1 csb low end");
        pin(t+225, 0, F_CSB, 1, "t1 hold csb");     pin(t+225, 0, F_IO, 0, "t1 hold upd");
        pin(t+226, 0, F_IO, 1, "t1 upd first");     pin(t+229, 0, F_IO, 1, "t1 upd last");
        pin(t+230, 0, F_IO, 0, "t1 upd off");       pin(t+229, 0, F_RDY, 0, "t1 ready early");
        pin(t+230, 0, F_RDY, 1, "t1 ready");        pin(t+230, 0, F_DONE, 1, "t1 done");
        pin(t+231, 0, F_DONE, 0, "t1 done width");
        bytes_at(t+225, 0, 7, 112'h00100412345678, "t1");
        io_at(t+231, 0, 1, "t1 upd pulses");
        goto(t+232);

        // Two channels in one frame.
        go(0, 4'b0011, {64'h0, 32'hDEADBEEF, 32'h12345678}, t);
        pin(t+448, 0, F_CSB, 0, "t2 csb low end");  pin(t+449, 0, F_CSB, 1, "t2 hold csb");
        pin(t+450, 0, F_IO, 1, "t2 upd first");     pin(t+454, 0, F_IO, 0, "t2 upd off");
        pin(t+454, 0, F_RDY, 1, "t2 ready");        pin(t+454, 0, F_DONE, 1, "t2 done");
        bytes_at(t+449, 0, 14, 112'h00100412345678002004DEADBEEF, "t2");
        io_at(t+456, 0, 2, "t2 upd pulses");
        goto(t+457);

        // Empty mask: done only.
        go(0, 4'b0000, {64'h0, 32'hFFFFFFFF, 32'hFFFFFFFF}, t);
        pin(t+1, 0, F_DONE, 1, "t3 done");  pin(t+1, 0, F_RDY, 1, "t3 ready");
        pin(t+1, 0, F_CSB, 1, "t3 csb");    pin(t+2, 0, F_DONE, 0, "t3 done width");
        io_at(t+4, 0, 2, "t3 upd pulses");
        goto(t+5);

        // Inputs change and valid stays high during a frame.
        ftw_in[0] = {96'h0, 32'hA5A5A5A5}; mask_in[0] = 4'b0001; valid_in[0] = 1'b1;
        t = ecnt;
        step();
        goto(t+10);
        ftw_in[0] = {64'h0, 32'h11223344, 32'h0F0F0F0F}; mask_in[0] = 4'b0011;
        bytes_at(t+225, 0, 7, 112'h001004A5A5A5A5, "t4a");
        pin(t+229, 0, F_RDY, 0, "t4 busy");  pin(t+230, 0, F_RDY, 1, "t4 ready");
        pin(t+230, 0, F_CSB, 1, "t4 gap csb");  pin(t+231, 0, F_CSB, 0, "t4b csb start");
        t2 = t + 230;
        goto(t2+1);
        valid_in[0] = 1'b0;
        pin(t2+448, 0, F_CSB, 0, "t4b csb low end");  pin(t2+449, 0, F_CSB, 1, "t4b hold csb");
        bytes_at(t2+449, 0, 14, 112'h0010040F0F0F0F00200411223344, "t4b");
        io_at(t2+456, 0, 4, "t4 upd pulses");
        goto(t2+457);

        // Reset in the middle of bit 30.
        go(0, 4'b0001, {96'h0, 32'h12345678}, t);
        goto(t+121);
        rstn[0] = 1'b0;
        pin(t+121, 0, F_CSB, 1, "t5 rst csb");    pin(t+121, 0, F_SCLK, 0, "t5 rst sclk");
        pin(t+121, 0, F_SDIO, 0, "t5 rst sdio");  pin(t+121, 0, F_IO, 0, "t5 rst upd");
        pin(t+121, 0, F_RDY, 1, "t5 rst ready");  pin(t+121, 0, F_DONE, 0, "t5 rst done");
        repeat (3) step();
        rstn[0] = 1'b1;
        step();
        io_at(ecnt+1, 0, 4, "t5 no upd");
        go(0, 4'b0001, {96'h0, 32'h0000FFFF}, t);
        bytes_at(t+225, 0, 7, 112'h0010040000FFFF, "t5b");
        io_at(t+231, 0, 5, "t5b upd pulses");
        goto(t+232);

        // Four-channel instance, D=1, U=1, channels 1 and 3.
        go(1, 4'b1010, {32'h01020304, 32'h55555555, 32'hCAFEF00D, 32'hFFFFFFFF}, t);
        pin(t+1, 1, F_CSB, 0, "t6 csb start");  pin(t+224, 1, F_CSB, 0, "t6 csb end");
        pin(t+225, 1, F_CSB, 1, "t6 hold csb"); pin(t+225, 1, F_IO, 0, "t6 hold upd");
        pin(t+226, 1, F_IO, 1, "t6 upd");       pin(t+226, 1, F_RDY, 0, "t6 busy");
        pin(t+227, 1, F_IO, 0, "t6 upd off");   pin(t+227, 1, F_RDY, 1, "t6 ready");
        pin(t+227, 1, F_DONE, 1, "t6 done");
        bytes_at(t+225, 1, 14, 112'h002004CAFEF00D00800401020304, "t6");
        io_at(t+228, 1, 1, "t6 upd pulses");
        goto(t+232);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
